// File: rtl/pe_injector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_injector_pkg
//  Description : Shared NoC system package. It holds the channel width, the
//                flit-valid bit position and the flit-type field positions
//                used by both the router and the PE injector. It also holds
//                the injector state encoding and a small flit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_injector_pkg;

    // Router channel geometry
    localparam int CHANNEL_WIDTH = 16;
    localparam int VALID_BIT     = CHANNEL_WIDTH - 1;

    // Flit-type field sits just below the valid bit
    localparam int FLIT_TYPE_HI  = CHANNEL_WIDTH - 2;
    localparam int FLIT_TYPE_LO  = CHANNEL_WIDTH - 3;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEADER = 2'b01,
        FLIT_TAIL   = 2'b10
    } flit_type_e;

    // Injector control states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_e;

    // Return a flit with its valid bit forced high
    function automatic logic [CHANNEL_WIDTH-1:0] mark_valid(
        input logic [CHANNEL_WIDTH-1:0] flit
    );
        logic [CHANNEL_WIDTH-1:0] r;
        r            = flit;
        r[VALID_BIT] = 1'b1;
        return r;
    endfunction

endpackage : pe_injector_pkg
`default_nettype wire

// File: rtl/pe_injector_credit.sv
`default_nettype none
// ============================================================================
//  Module      : credit_counter
//  Description : Credit counter for the downstream router buffer. It starts
//                full, counts down on each send (dec) and up on each credit
//                return (inc). It saturates at BUFFER_DEPTH. The overflow
//                output flags a credit that arrives while already full.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_counter #(
    parameter int BUFFER_DEPTH = 4,
    parameter int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             available,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: inc and dec together cancel; saturate at both ends
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register, reset to a full buffer's worth of credits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign available = (count_q != '0);
    assign overflow  = inc && !dec && (count_q == FULL);

endmodule : credit_counter
`default_nettype wire

// File: rtl/pe_injector.sv
`default_nettype none
// ============================================================================
//  Module      : pe_injector
//  Description : Takes a whole packet from a processing element. It then
//                serialises the packet one flit per cycle onto a router
//                input channel, with credit-based flow control.
//                Optional macro CREDIT_CHECK_EN adds a sticky credit_error
//                output. This output flags a credit that is returned while
//                the counter is already full.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_injector
    import pe_injector_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    parameter int PACKET_FLITS = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pe_valid,
    output logic                                  pe_ready,
    input  logic [PACKET_FLITS*CHANNEL_WIDTH-1:0] pe_packet,
    output logic [CHANNEL_WIDTH-1:0]              channel_out,
    input  logic                                  credit_in,
`ifdef CREDIT_CHECK_EN
    output logic                                  credit_error,
`endif
    output logic                                  busy
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int IDX_W = $clog2(PACKET_FLITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_FLITS - 1);

    inj_state_e                           state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [PACKET_FLITS*CHANNEL_WIDTH-1:0] packet_q, packet_d;
    logic [CHANNEL_WIDTH-1:0]             chan_q, chan_d;

    logic                     w_available;
    logic                     w_send;
    logic [CNT_W-1:0]         w_credit_count;
    logic [CHANNEL_WIDTH-1:0] w_flits [PACKET_FLITS];

    // View the held packet as an array of flits, flit 0 in the LSBs
    for (genvar g = 0; g < PACKET_FLITS; g++) begin : g_flit
        assign w_flits[g] = packet_q[g*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    // A flit goes out only in SEND with a registered credit in hand
    assign w_send = (state_q == SEND) && w_available;

`ifdef CREDIT_CHECK_EN
    logic w_overflow;
    logic credit_error_q;

    credit_counter #(
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .inc       (credit_in),
        .dec       (w_send),
        .count     (w_credit_count),
        .available (w_available),
        .overflow  (w_overflow)
    );

    // Sticky flag for a credit returned while already full; cleared by reset only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_error_q <= 1'b0;
        end else if (w_overflow) begin
            credit_error_q <= 1'b1;
        end
    end

    assign credit_error = credit_error_q;
`else
    credit_counter #(
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_credit (
        .clk       (clk),
        .reset     (reset),
        .inc       (credit_in),
        .dec       (w_send),
        .count     (w_credit_count),
        .available (w_available),
        .overflow  ()
    );
`endif

    // Next-state, serializer and channel data; the channel stays zero unless a flit is sent
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        packet_d = packet_q;
        chan_d   = '0;
        case (state_q)
            IDLE: begin
                if (pe_valid) begin
                    packet_d = pe_packet;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (w_available) begin
                    chan_d = mark_valid(w_flits[idx_q]);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index, packet and registered channel output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            packet_q <= '0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            packet_q <= packet_d;
            chan_q   <= chan_d;
        end
    end

    assign channel_out = chan_q;
    assign pe_ready    = (state_q == IDLE);
    assign busy        = (state_q == SEND);

endmodule : pe_injector
`default_nettype wire

// File: doc/pe_injector.md
PE_INJECTOR -- requirements
Module: pe_injector

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 4, credits equal to the downstream router input buffer depth in flits.
REQ-002 SHALL have parameter PACKET_FLITS, default 5, flits per packet (header, body, tail); legal range 2..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port pe_valid, input, 1, PE offers a packet.
REQ-006 SHALL have port pe_ready, output, 1, injector accepts a packet this cycle.
REQ-007 SHALL have port pe_packet, input, PACKET_FLITS*CHANNEL_WIDTH, packet payload; flit 0 (header) in the LSBs.
REQ-008 SHALL have port channel_out, output, CHANNEL_WIDTH, flit to the router input port (router channel_*_din).
REQ-009 SHALL have port credit_in, input, 1, one-cycle credit return pulse from the router (router credit_out_*_dout).
REQ-010 SHALL have port busy, output, 1, a packet is held and not fully sent.

Function
REQ-011 channel_out SHALL be registered; bit CHANNEL_WIDTH-1 is the flit-valid bit; channel_out SHALL be all-zero in every cycle no flit is sent.
REQ-012 States SHALL be IDLE and SEND only.
REQ-013 In IDLE pe_ready SHALL be 1; in SEND it SHALL be 0.
REQ-014 In IDLE with pe_valid=1: SHALL latch pe_packet, clear the flit index to 0, and go to SEND. Otherwise SHALL stay in IDLE.
REQ-015 In SEND with credit_count>0: SHALL drive flit[index] on channel_out the next cycle with its valid bit forced to 1, decrement credit_count, and increment the index.
REQ-016 In SEND with credit_count=0: SHALL drive all-zero and hold the index (stall); no flit SHALL be sent without a credit.
REQ-017 When flit PACKET_FLITS-1 is sent, the state SHALL return to IDLE in the same edge; the next packet's first flit can follow back-to-back after one IDLE accept cycle.
REQ-018 Latency: a packet accepted at edge T with credits available SHALL put flit 0 on channel_out after edge T+1 and the tail after edge T+PACKET_FLITS.
REQ-019 credit_count SHALL be width clog2(BUFFER_DEPTH+1), and SHALL decide sends from its registered value only (a credit arriving this cycle is usable next cycle).
REQ-020 credit_in=1 with no send SHALL increment; send with no credit_in SHALL decrement; both in the same cycle SHALL leave the count unchanged.
REQ-021 credit_count SHALL saturate at BUFFER_DEPTH; an extra credit is dropped and does not wrap.
REQ-022 busy SHALL equal (state==SEND).

Reset
REQ-023 Asserting reset SHALL immediately force: state IDLE, credit_count=BUFFER_DEPTH, index=0, channel_out=0, pe_ready=1, busy=0, credit_error=0.
REQ-024 Reset mid-packet SHALL discard the held packet with no tail emitted; after release, operation SHALL resume from IDLE with full credits.

Configuration
REQ-025 Macro CREDIT_CHECK_EN defined: SHALL add output credit_error (1 bit), set sticky to 1 when credit_in=1 arrives with credit_count=BUFFER_DEPTH and no same-cycle send, and cleared only by reset.
REQ-026 Macro CREDIT_CHECK_EN undefined: the credit_error port and its logic SHALL be absent; saturation per REQ-021 still applies.

Structure
REQ-027 CHANNEL_WIDTH, the valid-bit position and the flit-type field positions SHALL come from the shared system header/package used by the router; the block SHALL define no local copies.
REQ-028 The credit counter SHALL be a sub-module credit_counter (parameter BUFFER_DEPTH; inputs inc and dec; outputs count, available, overflow); the FSM and serializer stay in pe_injector.

Verification
REQ-029 Reset, then one packet with flits 0x1..0x5 and credits returned every cycle -> flits 1..5 on consecutive cycles T+1..T+5 with the valid bit set, pe_ready=0 during send, then IDLE.
REQ-030 BUFFER_DEPTH=4, no credits returned -> exactly 4 flits sent, then channel_out=0 and busy=1; one credit_in pulse -> flit 5 appears two edges later.
REQ-031 Simultaneous credit_in and send at credit_count=2 -> count stays 2.
REQ-032 Two back-to-back packets with pe_valid held high -> 5 flits, one idle cycle, 5 flits; total flits never exceed credits.
REQ-033 Assert reset after flit 2 of 5 -> channel_out=0 immediately, credit_count=4 after release, and the next packet starts at flit 0.
REQ-034 With CREDIT_CHECK_EN defined, a credit_in pulse at full credits and idle -> credit_error=1 that persists until reset, and credit_count stays 4.
